// File: rtl/wb_trace_if.sv
// Trace stream port of wb_trace_monitor.
//   master: drives the head entry (tr_valid, tr_kind, tr_dst, tr_data, tr_seq)
//           and samples tr_ready.
//   slave : consumer side; samples the head entry and drives tr_ready.
interface wb_trace_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned SEQ_W      = 16
);
  logic                  tr_valid;
  logic                  tr_ready;
  logic                  tr_kind;
  logic [DM_ADDRESS-1:0] tr_dst;
  logic [DATA_W-1:0]     tr_data;
  logic [SEQ_W-1:0]      tr_seq;

  modport master (
    output tr_valid, tr_kind, tr_dst, tr_data, tr_seq,
    input  tr_ready
  );

  modport slave (
    input  tr_valid, tr_kind, tr_dst, tr_data, tr_seq,
    output tr_ready
  );
endinterface

// File: rtl/wb_trace_monitor.sv
// Observer that turns register write-backs and data-memory stores into an
// ordered, sequence-tagged event stream held in a small FIFO, and keeps a
// shadow copy of the register file.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   reg_write_sig/reg_num/reg_data : WB-stage register write
//   wr/addr/wr_data              : MEM-stage store
//   tr (wb_trace_if.master)      : valid/ready event stream, head entry
//   count, overflow, drop_count  : occupancy, sticky drop flag, drop counter
//   sh_addr/sh_data              : shadow register file read port (combinational)
module wb_trace_monitor #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned SEQ_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reg_write_sig,
  input  logic [4:0]                reg_num,
  input  logic [DATA_W-1:0]         reg_data,
  input  logic                      wr,
  input  logic [DM_ADDRESS-1:0]     addr,
  input  logic [DATA_W-1:0]         wr_data,
  wb_trace_if.master                tr,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [SEQ_W-1:0]          drop_count,
  input  logic [4:0]                sh_addr,
  output logic [DATA_W-1:0]         sh_data
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DSUM_W = SEQ_W + 1;

  typedef struct packed {
    logic                  kind;
    logic [DM_ADDRESS-1:0] dst;
    logic [DATA_W-1:0]     data;
    logic [SEQ_W-1:0]      seq;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [SEQ_W-1:0]  seq_ctr;
  logic [DATA_W-1:0] shadow [32];

  logic              r_ev_c;
  logic              s_ev_c;
  logic              r_acc_c;
  logic              s_acc_c;
  logic              pop_c;
  logic [CNT_W-1:0]  space_c;
  logic [1:0]        n_ev_c;
  logic [1:0]        n_push_c;
  logic [1:0]        n_drop_c;
  logic [DSUM_W-1:0] drop_sum_c;
  entry_t            r_entry_c;
  entry_t            s_entry_c;
  entry_t            head_c;

  // Event detection and acceptance; free space uses the pre-pop occupancy.
  always_comb begin
    r_ev_c     = reg_write_sig && (reg_num != 5'd0);
    s_ev_c     = wr;
    space_c    = CNT_W'(DEPTH) - count;
    // R always has priority for the last free slot.
    r_acc_c    = r_ev_c && (space_c != '0);
    s_acc_c    = s_ev_c && ((space_c >= CNT_W'(2)) ||
                            ((space_c == CNT_W'(1)) && !r_ev_c));
    n_ev_c     = 2'(r_ev_c) + 2'(s_ev_c);
    n_push_c   = 2'(r_acc_c) + 2'(s_acc_c);
    n_drop_c   = n_ev_c - n_push_c;
    pop_c      = (count != '0) && tr.tr_ready;
    drop_sum_c = {1'b0, drop_count} + DSUM_W'(n_drop_c);
    r_entry_c  = '{kind: 1'b0, dst: DM_ADDRESS'(reg_num), data: reg_data,
                   seq: seq_ctr};
    // A store shares the cycle's sequence base with R, so it takes +1 only if R fired.
    s_entry_c  = '{kind: 1'b1, dst: addr, data: wr_data,
                   seq: seq_ctr + SEQ_W'(r_ev_c)};
  end

  // Control state, counters and shadow register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      seq_ctr    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      for (int i = 0; i < 32; i++) shadow[i] <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PTR_W'(n_push_c);
      rd_ptr  <= rd_ptr + PTR_W'(pop_c);
      count   <= count + CNT_W'(n_push_c) - CNT_W'(pop_c);
      seq_ctr <= seq_ctr + SEQ_W'(n_ev_c);
      if (n_drop_c != 2'd0) overflow <= 1'b1;
      drop_count <= drop_sum_c[SEQ_W] ? '1 : drop_sum_c[SEQ_W-1:0];
      // Shadow tracks every R event, even ones the FIFO dropped.
      if (r_ev_c) shadow[reg_num] <= reg_data;
    end
  end

  // FIFO storage; R lands in the lower slot when both are accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_acc_c) mem[wr_ptr] <= r_entry_c;
      if (s_acc_c) mem[wr_ptr + PTR_W'(r_acc_c)] <= s_entry_c;
    end
  end

  // Head of FIFO, forced to zero when empty.
  always_comb begin
    head_c      = mem[rd_ptr];
    tr.tr_valid = (count != '0);
    tr.tr_kind  = tr.tr_valid ? head_c.kind : 1'b0;
    tr.tr_dst   = tr.tr_valid ? head_c.dst  : '0;
    tr.tr_data  = tr.tr_valid ? head_c.data : '0;
    tr.tr_seq   = tr.tr_valid ? head_c.seq  : '0;
  end

  assign sh_data = (sh_addr == 5'd0) ? '0 : shadow[sh_addr];

endmodule
